// File: rtl/tick_rate_ctrl_if.sv
// Mode-request port of the timebase rate controller.
// Valid/ready: a request transfers on a clock edge where req_valid && req_ready;
// the requester holds mode_req and req_valid stable until that edge.
interface tick_rate_ctrl_if;
  logic [1:0] mode_req;
  logic       req_valid;
  logic       req_ready;

  modport master (
    output mode_req,
    output req_valid,
    input  req_ready
  );

  modport slave (
    input  mode_req,
    input  req_valid,
    output req_ready
  );
endinterface

// File: rtl/tick_rate_ctrl.sv
// Clock-display timebase: divides clk_in into a 50%-duty clk_out plus a tick
// enable, with glitch-free runtime rate changes and a paused/single-step mode.
module tick_rate_ctrl #(
  parameter int unsigned DIV_NORMAL = 25000000,
  parameter int unsigned DIV_FAST   = 2500000,
  parameter int unsigned DIV_TURBO  = 2500,
  parameter int unsigned CW         = 26
) (
  input  logic             clk_in,
  input  logic             rst_n,
  tick_rate_ctrl_if.slave  req,
  input  logic             step,
  output logic             clk_out,
  output logic             tick,
  output logic [1:0]       mode_cur,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_PENDING = 2'd1,
    S_PAUSED  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_PAUSE = 2'd3;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    pend_mode;
  logic          accept;
  logic          at_term;

  // Terminal count (H-1) for the mode in effect; pause never runs the divider.
  function automatic logic [CW-1:0] term_of(input logic [1:0] m);
    case (m)
      2'd1:    term_of = CW'(DIV_FAST - 1);
      2'd2:    term_of = CW'(DIV_TURBO - 1);
      default: term_of = CW'(DIV_NORMAL - 1);
    endcase
  endfunction

  assign req.req_ready = (state != S_PENDING);
  assign accept        = req.req_valid && req.req_ready;
  assign at_term       = (cnt == term_of(mode_cur));
  assign state_dbg     = state;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RUN;
      cnt       <= '0;
      clk_out   <= 1'b0;
      tick      <= 1'b0;
      mode_cur  <= 2'd0;
      pend_mode <= 2'd0;
    end else begin
      tick <= 1'b0;
      case (state)
        S_RUN: begin
          if (at_term) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
            tick    <= ~clk_out;
          end else begin
            cnt <= cnt + 1'b1;
          end
          if (accept) begin
            pend_mode <= req.mode_req;
            state     <= S_PENDING;
          end
        end

        // The new mode lands only on a half-period boundary so clk_out never runts.
        S_PENDING: begin
          if (at_term) begin
            cnt      <= '0;
            clk_out  <= ~clk_out;
            tick     <= ~clk_out;
            mode_cur <= pend_mode;
            state    <= (pend_mode == MODE_PAUSE) ? S_PAUSED : S_RUN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_PAUSED: begin
          cnt <= '0;
          if (accept) begin
            mode_cur <= req.mode_req;
            state    <= (req.mode_req == MODE_PAUSE) ? S_PAUSED : S_RUN;
          end else if (step) begin
            clk_out <= ~clk_out;
            tick    <= ~clk_out;
          end
        end

        default: begin
          state <= S_RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_rate_ctrl.sv
// Directed bench for tick_rate_ctrl with DIV_NORMAL=5, DIV_FAST=3, DIV_TURBO=2.
module tb_tick_rate_ctrl;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_PAUSED  = 2'd2;

  logic       clk_in;
  logic       rst_n;
  logic       step;
  logic       clk_out;
  logic       tick;
  logic [1:0] mode_cur;
  logic [1:0] state_dbg;

  tick_rate_ctrl_if ifc ();

  tick_rate_ctrl #(
    .DIV_NORMAL (5),
    .DIV_FAST   (3),
    .DIV_TURBO  (2),
    .CW         (4)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .req       (ifc.slave),
    .step      (step),
    .clk_out   (clk_out),
    .tick      (tick),
    .mode_cur  (mode_cur),
    .state_dbg (state_dbg)
  );

  // clock/reset
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int total;
  int bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic clk_step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      clk_step();
      n++;
    end while (!tick && n < budget);
  endtask

  task automatic wait_fall(input int budget, output int n);
    n = 0;
    do begin
      clk_step();
      n++;
    end while (clk_out && n < budget);
  endtask

  task automatic send_req(input logic [1:0] m);
    ifc.mode_req  = m;
    ifc.req_valid = 1'b1;
  endtask

  task automatic drop_req();
    ifc.req_valid = 1'b0;
  endtask

  int n;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    step  = 1'b0;
    ifc.mode_req  = 2'd0;
    ifc.req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_clk_out", 32'(clk_out), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_mode", 32'(mode_cur), 0);
    chk("rst_ready", 32'(ifc.req_ready), 1);
    chk("rst_state", 32'(state_dbg), 32'(ST_RUN));
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;

    // 1: free run in normal mode, rise at edge 5, fall 10, ticks at 5, 15, 25
    wait_tick(20, n);  chk("t1_first_rise", 32'(n), 5);
    chk("t1_clk_hi", 32'(clk_out), 1);
    chk("t1_mode", 32'(mode_cur), 0);
    chk("t1_ready", 32'(ifc.req_ready), 1);
    wait_fall(20, n);  chk("t1_high_len", 32'(n), 5);
    wait_tick(20, n);  chk("t1_tick15", 32'(n), 5);
    wait_tick(20, n);  chk("t1_tick25", 32'(n), 10);
    clk_step();
    chk("t1_tick_one_cycle", 32'(tick), 0);

    // 2: fast request with counter at 1; applies at the counter-4 toggle
    send_req(2'd1);
    clk_step();
    drop_req();
    chk("t2_ready_low", 32'(ifc.req_ready), 0);
    chk("t2_state_pend", 32'(state_dbg), 32'(ST_PENDING));
    chk("t2_mode_old", 32'(mode_cur), 0);
    wait_fall(20, n);  chk("t2_boundary", 32'(n), 3);
    chk("t2_mode_new", 32'(mode_cur), 1);
    chk("t2_ready_back", 32'(ifc.req_ready), 1);
    wait_tick(20, n);  chk("t2_low_len", 32'(n), 3);
    wait_fall(20, n);  chk("t2_high_len", 32'(n), 3);
    wait_tick(20, n);  chk("t2_low_len2", 32'(n), 3);

    // 3: turbo held valid while a same-mode fast request is pending
    send_req(2'd1);
    clk_step();
    send_req(2'd2);
    chk("t3_ready_low", 32'(ifc.req_ready), 0);
    wait_fall(20, n);  chk("t3_fast_boundary", 32'(n), 2);
    chk("t3_mode_fast", 32'(mode_cur), 1);
    chk("t3_ready_up", 32'(ifc.req_ready), 1);
    clk_step();
    drop_req();
    chk("t3_turbo_accepted", 32'(ifc.req_ready), 0);
    chk("t3_mode_still_fast", 32'(mode_cur), 1);
    wait_tick(20, n);  chk("t3_turbo_boundary", 32'(n), 2);
    chk("t3_mode_turbo", 32'(mode_cur), 2);
    wait_fall(20, n);  chk("t3_turbo_high", 32'(n), 2);
    wait_tick(20, n);  chk("t3_turbo_low", 32'(n), 2);

    // 4: pause, three steps, then step collides with a normal request
    send_req(2'd3);
    clk_step();
    drop_req();
    chk("t4_ready_low", 32'(ifc.req_ready), 0);
    clk_step();
    chk("t4_paused_clk", 32'(clk_out), 0);
    chk("t4_mode_pause", 32'(mode_cur), 3);
    chk("t4_state_paused", 32'(state_dbg), 32'(ST_PAUSED));
    chk("t4_ready_paused", 32'(ifc.req_ready), 1);
    repeat (4) clk_step();
    chk("t4_frozen", 32'(clk_out), 0);
    step = 1'b1; clk_step(); step = 1'b0;
    chk("t4_step1_clk", 32'(clk_out), 1);
    chk("t4_step1_tick", 32'(tick), 1);
    clk_step();
    chk("t4_hold_clk", 32'(clk_out), 1);
    chk("t4_hold_tick", 32'(tick), 0);
    step = 1'b1; clk_step(); step = 1'b0;
    chk("t4_step2_clk", 32'(clk_out), 0);
    chk("t4_step2_tick", 32'(tick), 0);
    clk_step();
    step = 1'b1; clk_step(); step = 1'b0;
    chk("t4_step3_clk", 32'(clk_out), 1);
    chk("t4_step3_tick", 32'(tick), 1);
    clk_step();
    step = 1'b1;
    send_req(2'd0);
    clk_step();
    step = 1'b0;
    drop_req();
    chk("t4_collide_clk", 32'(clk_out), 1);
    chk("t4_collide_tick", 32'(tick), 0);
    chk("t4_collide_mode", 32'(mode_cur), 0);
    chk("t4_collide_state", 32'(state_dbg), 32'(ST_RUN));
    wait_fall(20, n);  chk("t4_run_high", 32'(n), 5);
    wait_tick(20, n);  chk("t4_run_low", 32'(n), 5);

    // 5: asynchronous reset while a turbo request is pending, clk_out high
    send_req(2'd2);
    clk_step();
    drop_req();
    chk("t5_state_pend", 32'(state_dbg), 32'(ST_PENDING));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_clk", 32'(clk_out), 0);
    chk("t5_rst_tick", 32'(tick), 0);
    chk("t5_rst_mode", 32'(mode_cur), 0);
    chk("t5_rst_ready", 32'(ifc.req_ready), 1);
    chk("t5_rst_state", 32'(state_dbg), 32'(ST_RUN));
    @(negedge clk_in);
    rst_n = 1'b1;
    wait_tick(20, n);  chk("t5_first_rise", 32'(n), 5);
    wait_fall(20, n);  chk("t5_high", 32'(n), 5);
    wait_tick(20, n);  chk("t5_low", 32'(n), 5);
    chk("t5_mode_lost", 32'(mode_cur), 0);

    // 6: step in RUN is ignored; same-mode request keeps edge timing
    step = 1'b1;
    clk_step();
    clk_step();
    step = 1'b0;
    chk("t6_step_ignored", 32'(clk_out), 1);
    wait_fall(20, n);  chk("t6_high_len", 32'(n), 3);
    send_req(2'd0);
    clk_step();
    drop_req();
    chk("t6_state_pend", 32'(state_dbg), 32'(ST_PENDING));
    chk("t6_ready_low", 32'(ifc.req_ready), 0);
    wait_tick(20, n);  chk("t6_low_len", 32'(n), 4);
    chk("t6_mode", 32'(mode_cur), 0);
    chk("t6_ready_back", 32'(ifc.req_ready), 1);
    chk("t6_state_run", 32'(state_dbg), 32'(ST_RUN));
    wait_fall(20, n);  chk("t6_high_after", 32'(n), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_rate_ctrl.md
# tick_rate_ctrl

Rate controller for the clock-display timebase. Divides `clk_in` into a 50 %-duty `clk_out` plus a one-cycle `tick` enable. The division rate is selected at runtime through a valid/ready request port: normal 1 Hz, fast, turbo (hour-rollover demo) or paused with single-step. Rate changes take effect only at a half-period boundary, so `clk_out` never glitches or emits a runt pulse. Sits between the board clock and the seconds/minutes/hours counters.

## Interface
- `DIV_NORMAL`, default 25000000: half-period in `clk_in` cycles for mode 0 (1 Hz from 50 MHz).
- `DIV_FAST`, default 2500000: half-period for mode 1.
- `DIV_TURBO`, default 2500: half-period for mode 2.
- `CW`, default 26: counter width; must hold max(DIV_*)−1; all DIV_* ≥ 2.

Ports:
- `clk_in` in 1: system clock, 50 MHz.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mode_req` in 2: requested mode; 0 normal, 1 fast, 2 turbo, 3 pause.
- `req_valid` in 1: `mode_req` is valid.
- `req_ready` out 1: controller can accept a request.
- `step` in 1: single-step pulse; honoured only in PAUSED.
- `clk_out` out 1: divided square wave, registered.
- `tick` out 1: one-cycle pulse, asserted in the same cycle `clk_out` goes 0→1.
- `mode_cur` out 2: mode currently in effect.

One clock; reset is asynchronous and active-low.

## Operation
- **States:** RUN, PENDING, PAUSED.
- **Reset values:** state RUN, counter 0, `clk_out` 0, `tick` 0, `mode_cur` 0, `req_ready` 1. Pending-mode register is 0.
- **Divider:** in RUN/PENDING, counter counts 0..H−1, where H is the DIV_* of `mode_cur`. At counter==H−1: counter←0 and `clk_out` toggles. If the toggle is 0→1, `tick`=1 for that cycle. Period is 2H cycles.
- **Handshake:** a request is accepted on `req_valid && req_ready`. `req_ready` = 1 in RUN and PAUSED, 0 in PENDING. `mode_req` is latched on acceptance.
- **RUN → PENDING:** on acceptance. The counter keeps running.
- **PENDING, at terminal count:** the toggle occurs as normal, then `mode_cur` ← latched mode, counter ← 0.
  - Latched mode 0–2 → RUN.
  - Latched mode 3 → PAUSED.
- **PAUSED:**
  - Counter is held at 0 and `clk_out` holds its value.
  - A `step` pulse toggles `clk_out` once (`tick` if 0→1).
  - An accepted request applies in the same edge: `mode_cur` ← `mode_req`, counter 0, next state RUN (mode 0–2) or PAUSED (mode 3). `req_ready` stays 1.
- **Same-mode request:** still goes through PENDING and applies at the boundary. No visible rate change.
- `step` outside PAUSED is ignored.
- `step` and an accepted request in the same cycle while PAUSED: the request wins and `step` is dropped.
- `req_valid` while `req_ready`=0: not accepted. The requester holds `req_valid`/`mode_req` until accepted.

## Timing
- All outputs are registered. `req_ready` is a decode of registered state.
- `req_ready` falls on the edge after acceptance. It rises on the edge that applies the mode.
- New rate latency: the first half-period in the new mode starts on the edge after the applying terminal count. Worst case is H_old cycles after acceptance.
- Step response: `clk_out` toggles on the edge that samples `step`=1. A multi-cycle `step` high toggles every cycle; upstream delivers a 1-cycle pulse.
- Counter wrap: the counter never exceeds H−1. There is no overflow path.
- Async reset at any point, including PENDING or PAUSED: outputs go to their reset values immediately. The pending request is discarded. After deassertion, the first `clk_out` rise is at the H-th `clk_in` edge.

## Test plan
Parameters for all scenarios: DIV_NORMAL=5, DIV_FAST=3, DIV_TURBO=2.
1. **Reset release, no requests:** `clk_out` rises at edge 5, falls at edge 10, period 10. `tick` is high exactly at edges 5, 15, 25. `mode_cur`=0 and `req_ready`=1 throughout.
2. **Fast request at counter=1:**
   - `req_ready`=0 from the next edge; `mode_cur` stays 0 until the counter-4 toggle, then becomes 1 and `req_ready`=1.
   - Subsequent period is 6 cycles with no short half-period.
3. **Back-to-back requests:** turbo held valid while PENDING. It is not accepted until `req_ready` returns, then applies at the next fast boundary; period becomes 4.
4. **Pause and step:**
   - Pause request: `clk_out` frozen at its post-boundary value and `mode_cur`=3.
   - Three `step` pulses give 3 toggles, with one `tick` per 0→1.
   - `step` together with a normal request in the same cycle: no toggle. `mode_cur`=0 next edge, RUN with period 10.
5. **Reset mid-PENDING (`rst_n` low asynchronously):** `clk_out`=0, `tick`=0, `mode_cur`=0, `req_ready`=1 before the next clock edge. After release, period 10 and the pending request is lost.
6. **Step in RUN and same-mode request:** `step` is ignored (edge timing unchanged). A mode-0 request while in mode 0 cycles PENDING→RUN with no change in `clk_out` timing.
